// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set by an accepted issue and cleared by writeback.
// Latency: busy state updates on the next edge; rd_busy/iss_stall are combinational.
// Backpressure: iss_stall refuses an issue whose destination still has an uncleared producer.
module rf_scoreboard #(
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [ADDR_W-1:0]    rd_addr_a,
    input  logic [ADDR_W-1:0]    rd_addr_b,
    input  logic                 iss_en,
    input  logic [ADDR_W-1:0]    iss_addr,
    output logic                 rd_busy_a,
    output logic                 rd_busy_b,
    output logic                 iss_stall,
    output logic [2**ADDR_W-1:0] busy_vec
);
    localparam int DEPTH = 2**ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic             zero_a;
    logic             zero_b;
    logic             zero_iss;
    logic             zero_wr;

    assign zero_a   = ZR && (rd_addr_a == '0);
    assign zero_b   = ZR && (rd_addr_b == '0);
    assign zero_iss = ZR && (iss_addr == '0);
    assign zero_wr  = ZR && (wr_addr == '0);

    // A same-cycle writeback to the register retires its producer, so it no longer counts as busy.
    assign rd_busy_a = busy[rd_addr_a] && !(wr_en && wr_addr == rd_addr_a) && !zero_a;
    assign rd_busy_b = busy[rd_addr_b] && !(wr_en && wr_addr == rd_addr_b) && !zero_b;
    assign iss_stall = iss_en && busy[iss_addr] && !(wr_en && wr_addr == iss_addr) && !zero_iss;
    assign busy_vec  = busy;

    // Set is applied after clear so a new producer wins over the retiring one.
    always_comb begin
        busy_nxt = busy;
        if (wr_en && !zero_wr)
            busy_nxt[wr_addr] = 1'b0;
        if (iss_en && !iss_stall && !zero_iss)
            busy_nxt[iss_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            busy <= '0;
        else
            busy <= busy_nxt;
    end
endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with write-to-read bypass, optional zero register and busy scoreboard.
// Latency: reads and busy flags are combinational; writes and issue effects land on the next edge.
// Backpressure: iss_stall blocks a WAW issue until the outstanding producer writes back.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [ADDR_W-1:0]    rd_addr_a,
    input  logic [ADDR_W-1:0]    rd_addr_b,
    output logic [DATA_W-1:0]    rd_data_a,
    output logic [DATA_W-1:0]    rd_data_b,
    output logic                 rd_busy_a,
    output logic                 rd_busy_b,
    input  logic                 iss_en,
    input  logic [ADDR_W-1:0]    iss_addr,
    output logic                 iss_stall,
    output logic [2**ADDR_W-1:0] busy_vec
);
    localparam int DEPTH = 2**ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs [DEPTH];
    logic              zero_wr;

    assign zero_wr = ZR && (wr_addr == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (wr_en && !zero_wr) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = regs[rd_addr_a];
        if (wr_en && wr_addr == rd_addr_a)
            rd_data_a = wr_data;
        if (ZR && rd_addr_a == '0)
            rd_data_a = '0;
    end

    always_comb begin
        rd_data_b = regs[rd_addr_b];
        if (wr_en && wr_addr == rd_addr_b)
            rd_data_b = wr_data;
        if (ZR && rd_addr_b == '0)
            rd_data_b = '0;
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .rd_busy_a (rd_busy_a),
        .rd_busy_b (rd_busy_b),
        .iss_stall (iss_stall),
        .busy_vec  (busy_vec)
    );
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: one instance with an ordinary register 0 and one with a hardwired zero register,
// driven by the same directed vectors and checked every cycle against a behavioural model.
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [2:0]  rd_addr_a = '0;
    logic [2:0]  rd_addr_b = '0;
    logic        iss_en = 1'b0;
    logic [2:0]  iss_addr = '0;

    logic [31:0] rd_data_a0, rd_data_b0, rd_data_a1, rd_data_b1;
    logic        rd_busy_a0, rd_busy_b0, rd_busy_a1, rd_busy_b1;
    logic        iss_stall0, iss_stall1;
    logic [7:0]  busy_vec0, busy_vec1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(0)) dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a0), .rd_data_b(rd_data_b0),
        .rd_busy_a(rd_busy_a0), .rd_busy_b(rd_busy_b0), .iss_en(iss_en), .iss_addr(iss_addr),
        .iss_stall(iss_stall0), .busy_vec(busy_vec0));

    reg_file_sb #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1)) dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a1), .rd_data_b(rd_data_b1),
        .rd_busy_a(rd_busy_a1), .rd_busy_b(rd_busy_b1), .iss_en(iss_en), .iss_addr(iss_addr),
        .iss_stall(iss_stall1), .busy_vec(busy_vec1));

    // Model state: index 0 mirrors dut0 (ordinary reg 0), index 1 mirrors dut1 (zero register).
    logic [31:0] m_reg  [2][8];
    logic [7:0]  m_busy [2];
    bit          model_valid = 1'b0;

    function automatic bit is_zero(int k, logic [2:0] a);
        return (k == 1) && (a == 3'd0);
    endfunction

    function automatic logic [31:0] exp_data(int k, logic [2:0] a);
        if (is_zero(k, a)) return 32'd0;
        if (wr_en && wr_addr == a) return wr_data;
        return m_reg[k][a];
    endfunction

    function automatic logic exp_rbusy(int k, logic [2:0] a);
        if (is_zero(k, a)) return 1'b0;
        return m_busy[k][a] && !(wr_en && wr_addr == a);
    endfunction

    function automatic logic exp_stall(int k);
        if (!iss_en || is_zero(k, iss_addr)) return 1'b0;
        return m_busy[k][iss_addr] && !(wr_en && wr_addr == iss_addr);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int r = 0; r < 8; r++) m_reg[k][r] = 32'd0;
                m_busy[k] = 8'd0;
            end else begin
                logic stall;
                stall = exp_stall(k);
                if (wr_en && !is_zero(k, wr_addr)) begin
                    m_reg[k][wr_addr]  = wr_data;
                    m_busy[k][wr_addr] = 1'b0;
                end
                if (iss_en && !stall && !is_zero(k, iss_addr))
                    m_busy[k][iss_addr] = 1'b1;
            end
        end
        if (reset) model_valid = 1'b1;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    logic [31:0] a_da [2], a_db [2];
    logic        a_ba [2], a_bb [2], a_st [2];
    logic [7:0]  a_bv [2];
    assign a_da[0] = rd_data_a0; assign a_da[1] = rd_data_a1;
    assign a_db[0] = rd_data_b0; assign a_db[1] = rd_data_b1;
    assign a_ba[0] = rd_busy_a0; assign a_ba[1] = rd_busy_a1;
    assign a_bb[0] = rd_busy_b0; assign a_bb[1] = rd_busy_b1;
    assign a_st[0] = iss_stall0; assign a_st[1] = iss_stall1;
    assign a_bv[0] = busy_vec0;  assign a_bv[1] = busy_vec1;

    always @(negedge clk) begin
        if (model_valid) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model rd_data_a dut%0d", k), a_da[k], exp_data(k, rd_addr_a));
                chk($sformatf("model rd_data_b dut%0d", k), a_db[k], exp_data(k, rd_addr_b));
                chk($sformatf("model rd_busy_a dut%0d", k), {31'd0, a_ba[k]}, {31'd0, exp_rbusy(k, rd_addr_a)});
                chk($sformatf("model rd_busy_b dut%0d", k), {31'd0, a_bb[k]}, {31'd0, exp_rbusy(k, rd_addr_b)});
                chk($sformatf("model iss_stall dut%0d", k), {31'd0, a_st[k]}, {31'd0, exp_stall(k)});
                chk($sformatf("model busy_vec dut%0d", k), {24'd0, a_bv[k]}, {24'd0, m_busy[k]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic we, logic [2:0] wa, logic [31:0] wd,
                         logic [2:0] ra, logic [2:0] rb, logic ie, logic [2:0] ia);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr_a = ra; rd_addr_b = rb; iss_en = ie; iss_addr = ia;
        #2;
    endtask

    initial begin
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 3'd0, 32'd0, 3'(i), 3'(7 - i), 1'b0, 3'd0);
            chk("reset rd_data_a", rd_data_a0, 32'd0);
            chk("reset rd_data_b", rd_data_b0, 32'd0);
            tick();
        end
        chk("reset rd_busy_a", {31'd0, rd_busy_a0}, 32'd0);
        chk("reset busy_vec", {24'd0, busy_vec0}, 32'd0);
        chk("reset iss_stall", {31'd0, iss_stall0}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 32'(8 - i), 3'd0, 3'd0, 1'b0, 3'd0);
            tick();
        end
        drive(1'b0, 3'd0, 32'd0, 3'd7, 3'd6, 1'b0, 3'd0);
        chk("read reg7", rd_data_a0, 32'd1);
        chk("read reg6", rd_data_b0, 32'd2);
        chk("zr reg7", rd_data_a1, 32'd1);
        drive(1'b0, 3'd0, 32'd0, 3'd0, 3'd0, 1'b0, 3'd0);
        chk("read reg0 ordinary", rd_data_a0, 32'd8);
        chk("read reg0 zero", rd_data_a1, 32'd0);
        tick();

        drive(1'b1, 3'd3, 32'hDEADBEEF, 3'd3, 3'd3, 1'b0, 3'd0);
        chk("bypass reg3", rd_data_a0, 32'hDEADBEEF);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd3, 3'd3, 1'b0, 3'd0);
        chk("written reg3", rd_data_a0, 32'hDEADBEEF);
        tick();

        drive(1'b0, 3'd0, 32'd0, 3'd5, 3'd5, 1'b1, 3'd5);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd5, 3'd5, 1'b0, 3'd5);
        chk("busy_vec5 set", {31'd0, busy_vec0[5]}, 32'd1);
        chk("rd_busy reg5", {31'd0, rd_busy_a0}, 32'd1);
        drive(1'b0, 3'd0, 32'd0, 3'd5, 3'd5, 1'b1, 3'd5);
        chk("WAW stall reg5", {31'd0, iss_stall0}, 32'd1);
        tick();
        chk("busy unchanged", {24'd0, busy_vec0}, 32'h20);
        drive(1'b1, 3'd5, 32'd42, 3'd5, 3'd5, 1'b1, 3'd5);
        chk("wb clears rd_busy", {31'd0, rd_busy_a0}, 32'd0);
        chk("wb clears stall", {31'd0, iss_stall0}, 32'd0);
        drive(1'b1, 3'd5, 32'd42, 3'd5, 3'd5, 1'b0, 3'd5);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd5, 3'd5, 1'b0, 3'd0);
        chk("busy5 cleared", {31'd0, busy_vec0[5]}, 32'd0);
        chk("reg5 data", rd_data_a0, 32'd42);

        drive(1'b0, 3'd0, 32'd0, 3'd2, 3'd2, 1'b1, 3'd2);
        tick();
        drive(1'b1, 3'd2, 32'd9, 3'd2, 3'd2, 1'b1, 3'd2);
        chk("wb+issue no stall", {31'd0, iss_stall0}, 32'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd2, 3'd2, 1'b0, 3'd0);
        chk("reg2 data", rd_data_a0, 32'd9);
        chk("busy2 reset by new producer", {31'd0, busy_vec0[2]}, 32'd1);

        drive(1'b0, 3'd0, 32'd0, 3'd0, 3'd0, 1'b1, 3'd1);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd0, 3'd0, 1'b1, 3'd4);
        tick();
        drive(1'b1, 3'd6, 32'd77, 3'd6, 3'd6, 1'b0, 3'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd6, 3'd6, 1'b0, 3'd0);
        chk("busy 1,2,4", {24'd0, busy_vec0}, 32'h16);
        chk("reg6 data", rd_data_a0, 32'd77);
        reset = 1'b1;
        drive(1'b1, 3'd6, 32'd99, 3'd6, 3'd6, 1'b1, 3'd3);
        tick();
        reset = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 3'd6, 3'd1, 1'b0, 3'd0);
        chk("reset clears busy", {24'd0, busy_vec0}, 32'd0);
        chk("reset wins reg6", rd_data_a0, 32'd0);
        drive(1'b1, 3'd1, 32'd5, 3'd6, 3'd1, 1'b0, 3'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd1, 3'd1, 1'b0, 3'd0);
        chk("post-reset write reg1", rd_data_a0, 32'd5);
        chk("post-reset busy reg1", {31'd0, rd_busy_a0}, 32'd0);

        drive(1'b0, 3'd0, 32'd0, 3'd0, 3'd0, 1'b1, 3'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd0, 3'd0, 1'b1, 3'd0);
        chk("issue reg0 ordinary busy", {24'd0, busy_vec0}, 32'd1);
        chk("issue reg0 zero no busy", {24'd0, busy_vec1}, 32'd0);
        chk("stall reg0 ordinary", {31'd0, iss_stall0}, 32'd1);
        chk("stall reg0 zero", {31'd0, iss_stall1}, 32'd0);
        chk("rd_busy reg0 zero", {31'd0, rd_busy_a1}, 32'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd0, 3'd0, 1'b0, 3'd0);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
